// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Round-robin arbiter that shares one memory-controller request port between
// two bus masters (port 0 = control unit, port 1 = loader/DMA). One request is
// latched at a time and held stable downstream until mem_ack. The owning port
// then gets a one-cycle completion. A watchdog aborts transactions that the
// controller never acknowledges.
//
// Ports
//   clk, nrst                      system clock, async active-low reset
//   pN_read_en / pN_write_en       level request per port, held until pN_ack
//   pN_dbl_byte_en                 1 = 16-bit access, 0 = 8-bit access
//   pN_addr, pN_wdata              byte address and write data
//   pN_ack, pN_err                 completion pulse, err = watchdog abort
//   pN_rdata                       read data, held until the next completion
//   mem_read_en / mem_write_en     request to the memory controller
//   mem_dbl_byte_en                access width to the controller
//   mem_addr, mem_wdata            address and write data to the controller
//   mem_ack, mem_rdata             controller completion and read data
//   grant                          one-hot owner in BUSY/DONE, 0 in IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate between requesting ports, latch the winner
// BUSY  | drive latched request to controller, wait for mem_ack/watchdog
// DONE  | one-cycle ack (and err) to owner, controller enables low

module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic        p0_read_en,
    input  logic        p0_write_en,
    input  logic        p0_dbl_byte_en,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [15:0] p0_rdata,

    input  logic        p1_read_en,
    input  logic        p1_write_en,
    input  logic        p1_dbl_byte_en,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [15:0] p1_rdata,

    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic        mem_dbl_byte_en,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,

    output logic [1:0]  grant
);

    // Counter is at least 8 bits and grows only if TIMEOUT needs more.
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               owner;
    logic               last;
    logic               we_q;
    logic               re_q;
    logic               dbl_q;
    logic               err_q;
    logic [15:0]        addr_q;
    logic [15:0]        wdata_q;
    logic [CNT_W-1:0]   cnt;

    logic               req0;
    logic               req1;
    logic               pick;
    logic               wd_expire;
    logic               busy;
    logic               done;

    assign req0 = p0_read_en | p0_write_en;
    assign req1 = p1_read_en | p1_write_en;

    // Tie goes to the port that did not finish last; otherwise whoever asks.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // cnt holds completed BUSY cycles, so the limit is hit on the
    // TIMEOUT-th BUSY cycle.
    assign wd_expire = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            dbl_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner   <= pick;
                        cnt     <= '0;
                        err_q   <= 1'b0;
                        we_q    <= pick ? p1_write_en    : p0_write_en;
                        re_q    <= pick ? p1_read_en     : p0_read_en;
                        dbl_q   <= pick ? p1_dbl_byte_en : p0_dbl_byte_en;
                        addr_q  <= pick ? p1_addr        : p0_addr;
                        wdata_q <= pick ? p1_wdata       : p0_wdata;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // mem_ack takes priority over a simultaneous watchdog expiry.
                    if (mem_ack) begin
                        if (re_q && !we_q) begin
                            if (owner) begin
                                p1_rdata <= mem_rdata;
                            end else begin
                                p0_rdata <= mem_rdata;
                            end
                        end
                        err_q <= 1'b0;
                        last  <= owner;
                        state <= DONE;
                    end else if (wd_expire) begin
                        err_q <= 1'b1;
                        last  <= owner;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    assign mem_read_en     = busy & re_q & ~we_q;
    assign mem_write_en    = busy & we_q;
    assign mem_dbl_byte_en = busy & dbl_q;
    assign mem_addr        = busy ? addr_q  : 16'h0000;
    assign mem_wdata       = busy ? wdata_q : 16'h0000;

    assign grant = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

    assign p0_ack = done & ~owner;
    assign p0_err = done & ~owner & err_q;
    assign p1_ack = done & owner;
    assign p1_err = done & owner & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        p0_read_en, p0_write_en, p0_dbl_byte_en;
    logic [15:0] p0_addr, p0_wdata, p0_rdata;
    logic        p0_ack, p0_err;
    logic        p1_read_en, p1_write_en, p1_dbl_byte_en;
    logic [15:0] p1_addr, p1_wdata, p1_rdata;
    logic        p1_ack, p1_err;
    logic        mem_read_en, mem_write_en, mem_dbl_byte_en;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [1:0]  grant;

    // Controller model: acks on the ack_delay-th cycle of an active request
    // (0 = never); force_ack pulses mem_ack regardless of state.
    int          ack_delay;
    int          bcnt;
    logic        force_ack;
    logic [15:0] mem_rdata_v;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          port;
        bit          err;
        logic [15:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        bit          port;
        bit          we;
        bit          re;
        bit          dbl;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          delay;
        logic [15:0] rdata;
        bit          exp_mre;
        bit          exp_mwe;
        bit          exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs[6];

    logic [15:0] sh0, sh1;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .p0_read_en      (p0_read_en),
        .p0_write_en     (p0_write_en),
        .p0_dbl_byte_en  (p0_dbl_byte_en),
        .p0_addr         (p0_addr),
        .p0_wdata        (p0_wdata),
        .p0_ack          (p0_ack),
        .p0_err          (p0_err),
        .p0_rdata        (p0_rdata),
        .p1_read_en      (p1_read_en),
        .p1_write_en     (p1_write_en),
        .p1_dbl_byte_en  (p1_dbl_byte_en),
        .p1_addr         (p1_addr),
        .p1_wdata        (p1_wdata),
        .p1_ack          (p1_ack),
        .p1_err          (p1_err),
        .p1_rdata        (p1_rdata),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .mem_dbl_byte_en (mem_dbl_byte_en),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .grant           (grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bcnt <= 0;
        end else if (mem_read_en || mem_write_en) begin
            bcnt <= bcnt + 1;
        end else begin
            bcnt <= 0;
        end
    end

    assign mem_ack = force_ack ||
                     ((mem_read_en || mem_write_en) && ack_delay != 0 && (bcnt + 1) == ack_delay);
    assign mem_rdata = mem_rdata_v;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit port, input bit err, input logic [15:0] rd);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rd;
        exp_q.push_back(e);
    endtask

    // Advance one cycle and check any completion against the scoreboard.
    task automatic tick(output bit acked);
        exp_t e;
        @(posedge clk);
        #1;
        acked = p0_ack || p1_ack;
        if (acked) begin
            chk1("ack_onehot", p0_ack && p1_ack, 1'b0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got p0_ack=%b p1_ack=%b required no ack (t=%0t)",
                         p0_ack, p1_ack, $time);
            end else begin
                e = exp_q.pop_front();
                chk1("ack_port", p1_ack, e.port);
                chk1("ack_err", p1_ack ? p1_err : p0_err, e.err);
                chk1("nonowner_err", p1_ack ? p0_err : p1_err, 1'b0);
                chk16("ack_rdata", p1_ack ? p1_rdata : p0_rdata, e.rdata);
            end
        end
    endtask

    task automatic drive_port(input bit port, input bit we, input bit re, input bit dbl,
                              input logic [15:0] addr, input logic [15:0] wdata);
        if (port) begin
            p1_write_en = we; p1_read_en = re; p1_dbl_byte_en = dbl;
            p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_write_en = we; p0_read_en = re; p0_dbl_byte_en = dbl;
            p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic check_all_zero(input string name);
        chk16(name, {7'd0, p0_ack, p0_err, p1_ack, p1_err, mem_read_en, mem_write_en,
                     mem_dbl_byte_en, grant}, 16'h0000);
        chk16({name, "_maddr"}, mem_addr, 16'h0000);
        chk16({name, "_mwdata"}, mem_wdata, 16'h0000);
        chk16({name, "_p0_rdata"}, p0_rdata, 16'h0000);
        chk16({name, "_p1_rdata"}, p1_rdata, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit          a;
        int          lat;
        int          nack;
        vec_t        v;
        logic [15:0] exp_rd;

        //                port we re dbl addr      wdata     dly rdata     mre mwe err lat
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000, 3, 16'hBEEF, 1'b1, 1'b0, 1'b0, 4};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0042, 16'h5A5A, 1, 16'hDEAD, 1'b0, 1'b1, 1'b0, 2};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0300, 16'h0000, 0, 16'h3333, 1'b1, 1'b0, 1'b1, 5};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, 4, 16'hC0DE, 1'b1, 1'b0, 1'b0, 5};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0500, 16'h0000, 5, 16'h9999, 1'b1, 1'b0, 1'b1, 5};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h00AB, 2, 16'h7777, 1'b0, 1'b1, 1'b0, 3};

        nrst = 1'b0;
        force_ack = 1'b0; ack_delay = 0; mem_rdata_v = 16'h0000;
        drive_port(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_port(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        sh0 = 16'h0000; sh1 = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        nrst = 1'b1;

        // ---------------- table-driven single transactions ----------------
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            ack_delay   = v.delay;
            mem_rdata_v = v.rdata;
            exp_rd = v.port ? sh1 : sh0;
            if (!v.exp_err && v.re && !v.we) exp_rd = v.rdata;
            if (v.port) sh1 = exp_rd; else sh0 = exp_rd;
            push_exp(v.port, v.exp_err, exp_rd);
            drive_port(v.port, v.we, v.re, v.dbl, v.addr, v.wdata);

            tick(a);
            lat = 1;
            chk16("vec_grant", {14'd0, grant}, v.port ? 16'h0002 : 16'h0001);
            chk1("vec_mem_read_en", mem_read_en, v.exp_mre);
            chk1("vec_mem_write_en", mem_write_en, v.exp_mwe);
            chk1("vec_mem_dbl", mem_dbl_byte_en, v.dbl);
            chk16("vec_mem_addr", mem_addr, v.addr);
            chk16("vec_mem_wdata", mem_wdata, v.wdata);
            while (!a && lat < 20) begin
                tick(a);
                lat++;
            end
            chk16("vec_latency", 16'(lat), 16'(v.exp_lat));
            chk1("vec_done_enables", mem_read_en | mem_write_en, 1'b0);
            chk16("vec_done_grant", {14'd0, grant}, v.port ? 16'h0002 : 16'h0001);
            drive_port(v.port, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            tick(a);
            chk16("vec_idle_grant", {14'd0, grant}, 16'h0000);
        end

        // ---------------- saturating writes from reset ----------------
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        sh0 = 16'h0000; sh1 = 16'h0000;
        ack_delay = 1; mem_rdata_v = 16'h0000;
        drive_port(1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 16'hA0A0);
        drive_port(1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 16'hB1B1);
        push_exp(1'b0, 1'b0, sh0);
        push_exp(1'b1, 1'b0, sh1);
        push_exp(1'b0, 1'b0, sh0);
        push_exp(1'b1, 1'b0, sh1);
        nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            tick(a);
            if (mem_write_en) begin
                chk16("sat_wdata", mem_wdata, (grant == 2'b10) ? 16'hB1B1 : 16'hA0A0);
                chk1("sat_read_en", mem_read_en, 1'b0);
            end
            if (a) begin
                nack++;
                if (nack == 4) begin
                    drive_port(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
                    drive_port(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
                end
            end
        end
        chk16("sat_ack_count", 16'(nack), 16'd4);
        tick(a);

        // ---------------- address change mid-BUSY ----------------
        ack_delay = 3; mem_rdata_v = 16'h4242;
        sh0 = 16'h4242;
        push_exp(1'b0, 1'b0, sh0);
        drive_port(1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
        a = 1'b0;
        for (int c = 0; c < 10 && !a; c++) begin
            tick(a);
            if (mem_read_en) begin
                chk16("hold_mem_addr", mem_addr, 16'h0010);
                p0_addr = 16'h0020;
                p0_dbl_byte_en = 1'b0;
            end
        end
        chk1("hold_acked", a, 1'b1);
        drive_port(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick(a);

        // ---------------- stray mem_ack in IDLE ----------------
        ack_delay = 0; mem_rdata_v = 16'hFFFF; force_ack = 1'b1;
        tick(a);
        chk1("late_ack_no_ack", a, 1'b0);
        tick(a);
        force_ack = 1'b0;
        chk16("late_ack_grant", {14'd0, grant}, 16'h0000);
        chk16("late_ack_p0_rdata", p0_rdata, sh0);
        chk1("late_ack_enables", mem_read_en | mem_write_en, 1'b0);

        // ---------------- reset mid-BUSY, then tie ----------------
        ack_delay = 0;
        drive_port(1'b1, 1'b0, 1'b1, 1'b1, 16'h0600, 16'h0000);
        tick(a);
        chk1("rst_busy_pre", mem_read_en, 1'b1);
        nrst = 1'b0;
        #1;
        check_all_zero("rst_busy");
        drive_port(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        sh0 = 16'h1111; sh1 = 16'h1111;
        ack_delay = 1; mem_rdata_v = 16'h1111;
        push_exp(1'b0, 1'b0, sh0);
        push_exp(1'b1, 1'b0, sh1);
        drive_port(1'b0, 1'b0, 1'b1, 1'b1, 16'h0700, 16'h0000);
        drive_port(1'b1, 1'b0, 1'b1, 1'b1, 16'h0800, 16'h0000);
        nack = 0;
        for (int c = 0; c < 20 && nack < 2; c++) begin
            tick(a);
            if (p0_ack) drive_port(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            if (p1_ack) drive_port(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            if (a) nack++;
        end
        chk16("tie_ack_count", 16'(nack), 16'd2);
        tick(a);
        chk16("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
